key_event_detector: RTL
=======================

Name: key_event_detector

Overview:
Button front-end that sits directly upstream of the LED mode/speed controller and turns a raw, bouncing push-button pin into clean single-cycle event pulses. It synchronises the pin, debounces it, and classifies presses as press, single click, double click or long press. Its key_flag output drives the same one-cycle press-pulse interface the LED controller already consumes. The added click, double and long events allow richer mode control.

Parameters:
DEBOUNCE_CYCLES, 2_500_000, consecutive stable cycles needed to accept a level change (20 ms at 125 MHz).
LONG_CYCLES, 125_000_000, hold time (in cycles, counted from the debounced press) that fires key_long (1 s).
DOUBLE_CYCLES, 37_500_000, maximum release-to-press gap for a double click (300 ms).
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (pull-up button); 0 = pin reads 1 when pressed.

Ports:
sysclk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
key  input  1  raw asynchronous button pin.
key_level  output  1  debounced level; 1 = pressed.
key_flag  output  1  one-cycle pulse on every debounced press.
key_click  output  1  one-cycle pulse: single short press confirmed (no second press within window).
key_double  output  1  one-cycle pulse: second press within DOUBLE_CYCLES of a short press's release.
key_long  output  1  one-cycle pulse: press held for LONG_CYCLES.

Behaviour:
- Reset: the whole block resets synchronously (rst sampled on sysclk). All outputs go to 0. Synchroniser flops go to the released level. All counters go to 0. FSM goes to IDLE. Reset mid-operation discards any pending click, double or long; no pulse is emitted while rst=1 or in the cycle after rst deasserts.
- Synchroniser: two flops on key, then polarity fix: raw_pressed = ACTIVE_LOW ? ~sync : sync.
- Debounce:
  - deb_cnt increments each cycle raw_pressed != key_level.
  - deb_cnt clears to 0 in any cycle where raw_pressed == key_level.
  - When deb_cnt == DEBOUNCE_CYCLES-1 and raw still differs, key_level toggles and deb_cnt clears.
  - Any glitch shorter than DEBOUNCE_CYCLES never changes key_level.
  - Pin-to-key_level latency is DEBOUNCE_CYCLES+2 cycles.
- Edges: press_e = key_level rose last cycle; rel_e = key_level fell last cycle. Both are registered.
- key_flag: equals press_e. It is high for exactly the one cycle after key_level rises, on every press, regardless of FSM state.
- FSM states: IDLE, PRESS1, GAP, PRESS2.
  - IDLE: on press_e, go to PRESS1, clear hold_cnt, clear long_done.
  - PRESS1:
    - hold_cnt increments each cycle.
    - When hold_cnt == LONG_CYCLES-1 and long_done=0, pulse key_long and set long_done. key_long fires once per press. hold_cnt saturates.
    - On rel_e: if long_done=1, go to IDLE with no click. Otherwise go to GAP and clear gap_cnt.
  - GAP:
    - gap_cnt increments each cycle.
    - On press_e while gap_cnt < DOUBLE_CYCLES, pulse key_double and go to PRESS2.
    - Else, when gap_cnt == DOUBLE_CYCLES-1, pulse key_click and go to IDLE.
    - If press_e and timeout occur in the same cycle, press wins: key_double fires and key_click does not.
  - PRESS2: no long detection. On rel_e, go to IDLE. A third quick press starts a fresh sequence from IDLE.
- Event pulses key_click, key_double and key_long are registered, one cycle wide, and mutually exclusive in any cycle. key_flag may coincide with key_double.
- Counter widths: $clog2(parameter+1). No counter wraps; each saturates or clears as above.

Test Plan:
Sim parameters: DEBOUNCE_CYCLES=8, LONG_CYCLES=100, DOUBLE_CYCLES=40, ACTIVE_LOW=1.
1. Bounce rejection: key toggles 0/1 every 3 cycles for 30 cycles, then stays 1 -> key_level stays 0; no pulse on any output.
2. Single click: key=0 for 30 cycles, then 1 -> key_level=1 exactly 10 cycles after the falling pin edge. key_flag pulses once, the cycle after key_level rises. key_click pulses once, 40 cycles after the rel_e cycle. No key_double or key_long.
3. Double click: press 30 cycles, release 20, press 30 -> key_flag pulses twice. key_double pulses once, coincident with the 2nd key_flag. No key_click.
4. Long press: key=0 for 150 cycles -> key_flag once. key_long once, 100 cycles after press_e (not repeated). On release, no key_click.
5. Gap boundary: second press_e arrives exactly at gap_cnt == DOUBLE_CYCLES-1 -> key_double fires, key_click does not. Press_e one cycle later -> key_click at timeout, then a fresh key_flag.
6. Reset mid-operation: assert rst for 2 cycles while in GAP -> all outputs 0 and state IDLE. No key_click afterwards. The next press behaves as in scenario 2.

Source files
------------

// File: rtl/key_event_detector.sv
// Push-button front end: synchronise, debounce and classify presses
// into press, click, double-click and long-press pulses.
module key_event_detector #(
    parameter int DEBOUNCE_CYCLES = 2_500_000,
    parameter int LONG_CYCLES     = 125_000_000,
    parameter int DOUBLE_CYCLES   = 37_500_000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic sysclk,
    input  logic rst,
    input  logic key,
    output logic key_level,
    output logic key_flag,
    output logic key_click,
    output logic key_double,
    output logic key_long
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam int GW = $clog2(DOUBLE_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(DOUBLE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_MAX   = GW'(DOUBLE_CYCLES);
    localparam logic          RELEASED  = ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS1 = 2'd1,
        GAP    = 2'd2,
        PRESS2 = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            sync1;
    logic            sync2;
    logic            raw_pressed;
    logic [DW-1:0]   deb_cnt;
    logic            level_d;
    logic            rise;
    logic            fall;
    logic            press_e;
    logic [LW-1:0]   hold_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            long_done;
    logic            long_hit;
    logic            click_nxt;
    logic            double_nxt;
    logic            long_nxt;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync1 <= RELEASED;
            sync2 <= RELEASED;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    assign raw_pressed = ACTIVE_LOW ? ~sync2 : sync2;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            key_level <= 1'b0;
            deb_cnt   <= '0;
        end else if (raw_pressed == key_level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            key_level <= ~key_level;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // The FSM acts on the edge in the cycle it is seen, so its
    // registered pulses line up with the registered press_e.
    assign rise = key_level & ~level_d;
    assign fall = ~key_level & level_d;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            level_d <= 1'b0;
            press_e <= 1'b0;
        end else begin
            level_d <= key_level;
            press_e <= rise;
        end
    end

    assign key_flag = press_e;

    assign long_hit = (state == PRESS1) && !long_done
                      && (hold_cnt == LONG_LAST);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (rise) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (fall) state_nxt = (long_done || long_hit) ? IDLE : GAP;
            end
            GAP: begin
                if (rise && gap_cnt < GAP_MAX) state_nxt = PRESS2;
                else if (gap_cnt == GAP_LAST)  state_nxt = IDLE;
            end
            PRESS2: begin
                if (fall) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        long_nxt   = long_hit;
        double_nxt = 1'b0;
        click_nxt  = 1'b0;
        if (state == GAP) begin
            if (rise && gap_cnt < GAP_MAX) double_nxt = 1'b1;
            else if (gap_cnt == GAP_LAST)  click_nxt  = 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
        end else if (state == IDLE && rise) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
        end else if (state == PRESS1) begin
            if (hold_cnt != LONG_LAST) hold_cnt <= hold_cnt + 1'b1;
            if (long_hit)              long_done <= 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (state == PRESS1 && fall) begin
            gap_cnt <= '0;
        end else if (state == GAP && gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            key_click  <= 1'b0;
            key_double <= 1'b0;
            key_long   <= 1'b0;
        end else begin
            key_click  <= click_nxt;
            key_double <= double_nxt;
            key_long   <= long_nxt;
        end
    end

endmodule
